// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response bundle between a CPU core (master) and its data memory (slave).
interface dbus_sram_responder_if;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder.sv
// Single-outstanding data-bus responder backed by a word-wide SRAM with byte-lane writes.
// Read data is captured at acceptance and presented after a fixed LATENCY.
module dbus_sram_responder #(
  parameter int WORDS_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  dbus_sram_responder_if.slave  bus
);
  localparam int         DATA_W    = 32;
  localparam int         DEPTH     = 2 ** WORDS_LOG2;
  localparam logic [3:0] LAST_WAIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    accept;
  logic                    is_write;
  logic                    addr_ok;
  logic                    data_ok;
  logic [WORDS_LOG2-1:0]   idx;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DATA_W-1:0]       rdata_p1;
  logic                    unused_req;

  assign idx      = bus.dreq.addr[WORDS_LOG2+1:2];
  assign is_write = |bus.dreq.strobe;

  // Size, byte offset and aliased upper address bits play no part in the access.
  assign unused_req = ^{bus.dreq.size, bus.dreq.addr[31:WORDS_LOG2+2], bus.dreq.addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        // Gated by resetn so addr_ok drops the instant reset asserts.
        addr_ok = bus.dreq.valid & resetn;
        accept  = addr_ok;
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == LAST_WAIT) begin
          state_nxt = S_RESP;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_RESP: begin
        data_ok   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: response data captured at the accept edge, held until the next accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_p1 <= '0;
    end else if (accept) begin
      rdata_p1 <= is_write ? '0 : mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.dreq.strobe[i]) begin
          mem[idx][8*i +: 8] <= bus.dreq.data[8*i +: 8];
        end
      end
    end
  end

  assign bus.dresp = {addr_ok, data_ok, rdata_p1};

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder: three instances at LATENCY 2, 3 and 1.
module tb_dbus_sram_responder;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        req_valid [3];
  logic [31:0] req_addr  [3];
  logic [3:0]  req_strb  [3];
  logic [31:0] req_data  [3];
  logic        aok  [3];
  logic        dok  [3];
  logic [31:0] rdat [3];

  dbus_sram_responder_if bi0 ();
  dbus_sram_responder_if bi1 ();
  dbus_sram_responder_if bi2 ();

  assign bi0.dreq = {req_valid[0], req_addr[0], 3'd2, req_strb[0], req_data[0]};
  assign bi1.dreq = {req_valid[1], req_addr[1], 3'd2, req_strb[1], req_data[1]};
  assign bi2.dreq = {req_valid[2], req_addr[2], 3'd2, req_strb[2], req_data[2]};

  assign aok[0] = bi0.dresp.addr_ok;  assign dok[0] = bi0.dresp.data_ok;  assign rdat[0] = bi0.dresp.data;
  assign aok[1] = bi1.dresp.addr_ok;  assign dok[1] = bi1.dresp.data_ok;  assign rdat[1] = bi1.dresp.data;
  assign aok[2] = bi2.dresp.addr_ok;  assign dok[2] = bi2.dresp.data_ok;  assign rdat[2] = bi2.dresp.data;

  dbus_sram_responder #(.WORDS_LOG2(12), .LATENCY(2)) u_dut0 (.clk(clk), .resetn(resetn), .bus(bi0));
  dbus_sram_responder #(.WORDS_LOG2(12), .LATENCY(3)) u_dut1 (.clk(clk), .resetn(resetn), .bus(bi1));
  dbus_sram_responder #(.WORDS_LOG2(12), .LATENCY(1)) u_dut2 (.clk(clk), .resetn(resetn), .bus(bi2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One complete transaction on instance k, started from an idle responder.
  task automatic xact(input int k, input int lat, input logic [31:0] addr, input logic [3:0] strb,
                      input logic [31:0] data, input logic [31:0] exp, input string name);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    req_valid[k] = 1'b1; req_addr[k] = addr; req_strb[k] = strb; req_data[k] = data;
    @(negedge clk);
    while (aok[k] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({name, " accept_wait"}, 32'(waited), 32'd0);
    check({name, " addr_ok"}, 32'(aok[k]), 32'd1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      check($sformatf("%s data_ok@%0d", name, i), 32'(dok[k]), 32'(i == lat));
      check($sformatf("%s addr_ok@%0d", name, i), 32'(aok[k]), 32'd0);
      if (i == lat) check({name, " data"}, rdat[0 + k], exp);
    end
  endtask

  // Accept a request on instance 0, then pull reset in the middle of its WAIT cycle.
  task automatic reset_mid_wait(input logic [31:0] addr, input logic [3:0] strb,
                                input logic [31:0] data, input logic [31:0] loaded, input string name);
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_addr[0] = addr; req_strb[0] = strb; req_data[0] = data;
    @(negedge clk);
    check({name, " addr_ok"}, 32'(aok[0]), 32'd1);
    @(posedge clk); #2;
    check({name, " loaded"}, rdat[0], loaded);
    #1 resetn = 1'b0;
    #1;
    check({name, " rst addr_ok"}, 32'(aok[0]), 32'd0);
    check({name, " rst data_ok"}, 32'(dok[0]), 32'd0);
    check({name, " rst data"}, rdat[0], 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    req_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("%s stray data_ok@%0d", name, i), 32'(dok[0]), 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'h0000_0040, 4'hF, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{32'h0000_0040, 4'h0, 32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{32'h0000_0080, 4'hF, 32'h1122_3344, 32'h0};
    tbl[3]  = '{32'h0000_0080, 4'h5, 32'hAABB_CCDD, 32'h0};
    tbl[4]  = '{32'h0000_0080, 4'h0, 32'h0,         32'h11BB_33DD};
    tbl[5]  = '{32'h0000_4004, 4'hF, 32'h1234_5678, 32'h0};
    tbl[6]  = '{32'h0000_0004, 4'h0, 32'h0,         32'h1234_5678};
    tbl[7]  = '{32'h0000_0083, 4'h0, 32'h0,         32'h11BB_33DD};
    tbl[8]  = '{32'h0000_3FFC, 4'hF, 32'hFFFF_FFFF, 32'h0};
    tbl[9]  = '{32'h0000_3FFC, 4'h2, 32'h0000_0000, 32'h0};
    tbl[10] = '{32'hFFFF_3FFC, 4'h0, 32'h0,         32'hFFFF_00FF};

    resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; req_strb[k] = '0; req_data[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset addr_ok%0d", k), 32'(aok[k]), 32'd0);
      check($sformatf("reset data_ok%0d", k), 32'(dok[k]), 32'd0);
      check($sformatf("reset data%0d", k), rdat[k], 32'd0);
    end
    resetn = 1'b1;

    for (int i = 0; i < 11; i++)
      xact(0, 2, tbl[i].addr, tbl[i].strb, tbl[i].data, tbl[i].exp, $sformatf("vec%0d", i));

    reset_mid_wait(32'h0000_0040, 4'h0, 32'h0, 32'hDEAD_BEEF, "rst_rd");
    reset_mid_wait(32'h0000_0100, 4'hF, 32'h55AA_55AA, 32'h0, "rst_wr");
    xact(0, 2, 32'h0000_0100, 4'h0, 32'h0, 32'h55AA_55AA, "post_rst_wr");
    xact(0, 2, 32'h0000_0040, 4'h0, 32'h0, 32'hDEAD_BEEF, "post_rst_rd");

    // Valid held continuously at LATENCY=3: one accept and one data_ok every 4 cycles.
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_addr[1] = 32'h0; req_strb[1] = 4'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("hold addr_ok c%0d", c), 32'(aok[1]), 32'((c % 4) == 0));
      check($sformatf("hold data_ok c%0d", c), 32'(dok[1]), 32'((c % 4) == 3));
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;

    for (int i = 0; i < 8; i++)
      xact(2, 1, 32'(4 * i), 4'hF, 32'hC0DE_0000 + 32'(i) * 32'h0101_0101, 32'h0, $sformatf("l1_wr%0d", i));
    for (int i = 0; i < 8; i++)
      xact(2, 1, 32'(4 * i), 4'h0, 32'h0, 32'hC0DE_0000 + 32'(i) * 32'h0101_0101, $sformatf("l1_rd%0d", i));

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
